// File: rtl/ysyx_25020047_lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, op-code bit positions
// and the FSM state encoding.
package ysyx_25020047_lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // in_op layout: {mem_en, is_store, unsigned, size[1:0]}
  localparam int OP_MEM_EN   = 4;
  localparam int OP_STORE    = 3;
  localparam int OP_UNSIGNED = 2;
  localparam int OP_SIZE_HI  = 1;
  localparam int OP_SIZE_LO  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// Byte-lane steering for the LSU: extracts and extends load data from the aligned
// bus word, shifts store data into its lanes, and flags misaligned accesses.
module ysyx_25020047_lsu_align
  import ysyx_25020047_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ext_rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  wmask,
  output logic        misaligned
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [4:0]  shamt;

  always_comb begin
    shamt = {addr_lo, 3'b000};
    case (addr_lo)
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
    rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Size encoding 3 is unused by the decoder and treated as a word access.
    ext_rdata  = rdata;
    lane_wdata = wdata;
    wmask      = 4'hF;
    misaligned = (addr_lo != 2'b00);
    case (size)
      SIZE_B: begin
        ext_rdata  = {{24{~is_unsigned & rbyte[7]}}, rbyte};
        lane_wdata = {24'h0, wdata[7:0]} << shamt;
        wmask      = 4'b0001 << addr_lo;
        misaligned = 1'b0;
      end
      SIZE_H: begin
        ext_rdata  = {{16{~is_unsigned & rhalf[15]}}, rhalf};
        lane_wdata = {16'h0, wdata[15:0]} << shamt;
        wmask      = 4'b0011 << addr_lo;
        misaligned = addr_lo[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit between EXU and WBU: one aligned 32-bit bus transaction per
// instruction, with misalignment detection and a response timeout.
module ysyx_25020047_lsu
  import ysyx_25020047_lsu_pkg::*;
#(
  parameter int RESP_TIMEOUT = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_op,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_memdata,
  output logic        out_err
);

  localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

  lsu_state_e state, next_state;

  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             store_q;
  logic             unsigned_q;
  logic [1:0]       size_q;
  logic [31:0]      memdata_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]  sel_addr_lo;
  logic [1:0]  sel_size;
  logic        sel_unsigned;
  logic [31:0] ext_rdata;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wmask;
  logic        misaligned;
  logic        timeout;

  // In IDLE the aligner looks at the incoming op to judge misalignment; afterwards
  // it works on the latched op so bus fields stay stable during the transaction.
  assign sel_addr_lo  = (state == IDLE) ? in_addr[1:0] : addr_q[1:0];
  assign sel_size     = (state == IDLE) ? in_op[OP_SIZE_HI:OP_SIZE_LO] : size_q;
  assign sel_unsigned = (state == IDLE) ? in_op[OP_UNSIGNED] : unsigned_q;
  assign timeout      = (cnt_q == CNT_LAST);

  ysyx_25020047_lsu_align u_align (
    .addr_lo     (sel_addr_lo),
    .size        (sel_size),
    .is_unsigned (sel_unsigned),
    .rdata       (mem_rdata),
    .wdata       (wdata_q),
    .ext_rdata   (ext_rdata),
    .lane_wdata  (lane_wdata),
    .wmask       (lane_wmask),
    .misaligned  (misaligned)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!in_op[OP_MEM_EN] || misaligned) next_state = DONE;
          else                                 next_state = REQ;
        end
      end
      REQ: begin
        if (timeout)            next_state = DONE;
        else if (mem_req_ready) next_state = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid || timeout) next_state = DONE;
      end
      DONE: begin
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // A response arriving on the timeout cycle still wins; after that the op is closed.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= SIZE_B;
      memdata_q  <= 32'h0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            addr_q     <= in_addr;
            wdata_q    <= in_wdata;
            store_q    <= in_op[OP_STORE];
            unsigned_q <= in_op[OP_UNSIGNED];
            size_q     <= in_op[OP_SIZE_HI:OP_SIZE_LO];
            memdata_q  <= 32'h0;
            err_q      <= in_op[OP_MEM_EN] & misaligned;
            cnt_q      <= '0;
          end
        end
        REQ, WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (state == WAIT && mem_resp_valid) begin
            memdata_q <= store_q ? 32'h0 : ext_rdata;
          end else if (timeout) begin
            memdata_q <= 32'h0;
            err_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign out_valid     = (state == DONE);
  assign mem_addr      = {addr_q[31:2], 2'b00};
  assign mem_wen       = store_q;
  assign mem_wdata     = lane_wdata;
  assign mem_wmask     = store_q ? lane_wmask : 4'b0000;
  assign out_memdata   = memdata_q;
  assign out_err       = err_q;

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Directed scoreboard bench for the LSU: expected results are queued when an op is
// issued and compared when the unit presents its result.
module tb_ysyx_25020047_lsu;

  // Long enough for the 5-cycle request stall plus 3-cycle response scenario.
  localparam int TB_TIMEOUT = 12;

  localparam logic [4:0] OP_NONE = 5'b00000;
  localparam logic [4:0] OP_LB   = 5'b10000;
  localparam logic [4:0] OP_LH   = 5'b10001;
  localparam logic [4:0] OP_LW   = 5'b10010;
  localparam logic [4:0] OP_LBU  = 5'b10100;
  localparam logic [4:0] OP_LHU  = 5'b10101;
  localparam logic [4:0] OP_SB   = 5'b11000;
  localparam logic [4:0] OP_SH   = 5'b11001;
  localparam logic [4:0] OP_SW   = 5'b11010;

  typedef struct {
    logic [31:0] memdata;
    logic        err;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_op;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_memdata;
  logic        out_err;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  ysyx_25020047_lsu #(.RESP_TIMEOUT(TB_TIMEOUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .in_op          (in_op),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_memdata    (out_memdata),
    .out_err        (out_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=hang expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge with the unit idle; returns one cycle after acceptance.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] op, input logic [31:0] exp_md,
                               input logic exp_err);
    exp_t e;
    expectEq("in_ready_before_issue", in_ready, 1);
    in_valid = 1'b1;
    in_addr  = addr;
    in_wdata = wdata;
    in_op    = op;
    e.memdata = exp_md;
    e.err     = exp_err;
    sb_q.push_back(e);
    @(negedge clock);
    in_valid = 1'b0;
    in_addr  = $urandom;
    in_wdata = $urandom;
    in_op    = OP_NONE;
  endtask

  task automatic serveBus(input string tag, input int req_delay, input int resp_delay,
                          input logic [31:0] rdata, input logic [31:0] e_addr,
                          input logic e_wen, input logic [31:0] e_wdata,
                          input logic [3:0] e_wmask);
    int n = 0;
    while (!mem_req_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    expectEq({tag, "_req_valid"}, mem_req_valid, 1);
    for (int i = 0; i <= req_delay; i++) begin
      expectEq({tag, "_addr"}, mem_addr, e_addr);
      expectEq({tag, "_wen"}, mem_wen, e_wen);
      expectEq({tag, "_wmask"}, mem_wmask, e_wmask);
      if (e_wen) expectEq({tag, "_wdata"}, mem_wdata, e_wdata);
      if (i == req_delay) mem_req_ready = 1'b1;
      @(negedge clock);
    end
    mem_req_ready = 1'b0;
    expectEq({tag, "_req_dropped"}, mem_req_valid, 0);
    for (int i = 1; i < resp_delay; i++) @(negedge clock);
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    mem_rdata      = $urandom;
  endtask

  task automatic checkOutput(input string tag, input int ready_delay);
    exp_t e;
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    expectEq({tag, "_out_valid"}, out_valid, 1);
    checks++;
    assert (sb_q.size() != 0) else begin
      failures++;
      $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      expectEq({tag, "_memdata"}, out_memdata, e.memdata);
      expectEq({tag, "_err"}, out_err, e.err);
      for (int i = 0; i < ready_delay; i++) begin
        @(negedge clock);
        expectEq({tag, "_held_valid"}, out_valid, 1);
        expectEq({tag, "_held_memdata"}, out_memdata, e.memdata);
        expectEq({tag, "_held_in_ready"}, in_ready, 0);
      end
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    expectEq({tag, "_consumed"}, out_valid, 0);
    expectEq({tag, "_back_idle"}, in_ready, 1);
  endtask

  initial begin
    int n;
    reset          = 1'b1;
    in_valid       = 1'b0;
    in_addr        = 32'h0;
    in_wdata       = 32'h0;
    in_op          = OP_NONE;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h0;
    out_ready      = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    $display("[TB] reset released");
    expectEq("rst_in_ready", in_ready, 1);
    expectEq("rst_out_valid", out_valid, 0);
    expectEq("rst_req_valid", mem_req_valid, 0);
    expectEq("rst_memdata", out_memdata, 32'h0);
    expectEq("rst_err", out_err, 0);

    // lbu from the top byte lane, zero-wait bus: result visible on the third cycle
    applyStimulus(32'h8000_0003, 32'h0, OP_LBU, 32'h0000_00AB, 1'b0);
    serveBus("lbu", 0, 1, 32'hAB00_0000, 32'h8000_0000, 1'b0, 32'h0, 4'b0000);
    expectEq("lbu_min_latency", out_valid, 1);
    checkOutput("lbu", 0);

    applyStimulus(32'h8000_0003, 32'h0, OP_LB, 32'hFFFF_FFAB, 1'b0);
    serveBus("lb", 0, 1, 32'hAB00_0000, 32'h8000_0000, 1'b0, 32'h0, 4'b0000);
    checkOutput("lb", 0);

    // store ack carries junk read data, which must not reach memdata
    applyStimulus(32'h8000_0002, 32'h1234_BEEF, OP_SH, 32'h0, 1'b0);
    serveBus("sh", 0, 1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'hBEEF_0000, 4'b1100);
    checkOutput("sh", 0);

    applyStimulus(32'h8000_0001, 32'h0, OP_LW, 32'h0, 1'b1);
    expectEq("lw_mis_latency", out_valid, 1);
    expectEq("lw_mis_no_req", mem_req_valid, 0);
    checkOutput("lw_mis", 0);
    expectEq("lw_mis_no_req_after", mem_req_valid, 0);

    applyStimulus(32'h0000_0001, 32'h5555_5555, OP_NONE, 32'h0, 1'b0);
    expectEq("nonmem_latency", out_valid, 1);
    expectEq("nonmem_no_req", mem_req_valid, 0);
    checkOutput("nonmem", 0);

    // stalled request and late response, then a slow consumer
    applyStimulus(32'h8000_0002, 32'h0, OP_LH, 32'hFFFF_8001, 1'b0);
    serveBus("lh_stall", 5, 3, 32'h8001_1234, 32'h8000_0000, 1'b0, 32'h0, 4'b0000);
    checkOutput("lh_stall", 4);
    @(negedge clock);
    expectEq("lh_single_valid", out_valid, 0);

    applyStimulus(32'h8000_0002, 32'h0, OP_LHU, 32'h0000_8001, 1'b0);
    serveBus("lhu", 0, 2, 32'h8001_1234, 32'h8000_0000, 1'b0, 32'h0, 4'b0000);
    checkOutput("lhu", 0);

    applyStimulus(32'h8000_0101, 32'hCAFE_0055, OP_SB, 32'h0, 1'b0);
    serveBus("sb", 1, 1, 32'h0, 32'h8000_0100, 1'b1, 32'h0000_5500, 4'b0010);
    checkOutput("sb", 0);

    applyStimulus(32'h8000_0008, 32'h89AB_CDEF, OP_SW, 32'h0, 1'b0);
    serveBus("sw", 0, 1, 32'h0, 32'h8000_0008, 1'b1, 32'h89AB_CDEF, 4'b1111);
    checkOutput("sw", 1);

    applyStimulus(32'h8000_000C, 32'h0, OP_LW, 32'h1234_5678, 1'b0);
    serveBus("lw", 0, 1, 32'h1234_5678, 32'h8000_000C, 1'b0, 32'h0, 4'b0000);
    checkOutput("lw", 0);

    // request accepted but never answered; a response after the abort is ignored
    mem_req_ready = 1'b1;
    applyStimulus(32'h8000_0010, 32'h0, OP_LW, 32'h0, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    mem_req_ready = 1'b0;
    expectEq("timeout_cycles", n, TB_TIMEOUT);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hDEAD_BEEF;
    checkOutput("timeout", 1);
    mem_resp_valid = 1'b0;
    @(negedge clock);
    expectEq("timeout_late_resp_ignored", out_valid, 0);

    // reset while waiting for the response drops the op entirely
    applyStimulus(32'h8000_0014, 32'h0, OP_LW, 32'h0, 1'b0);
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    expectEq("rst_wait_reached", mem_req_valid, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sb_q.delete();
    expectEq("midrst_in_ready", in_ready, 1);
    expectEq("midrst_out_valid", out_valid, 0);
    expectEq("midrst_req_valid", mem_req_valid, 0);
    expectEq("midrst_memdata", out_memdata, 32'h0);
    expectEq("midrst_err", out_err, 0);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1111_2222;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    expectEq("midrst_stays_idle", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
